// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register (valid/ready, synchronous flush, bubble counter).
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer and register the ready path.
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 144,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bubble,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic accept;
    logic take;

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // Ready depends only on state, so no combinational path from out_ready.
    assign in_ready = resetn & ~skid_valid;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            out_valid  <= 1'b0;
            out_bubble <= 1'b1;
            out_ctrl   <= '0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_bubble <= 1'b1;
            out_ctrl   <= '0;
            skid_valid <= 1'b0;
        end else if (take || !out_valid) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_bubble <= 1'b0;
                out_ctrl   <= skid_ctrl;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid  <= 1'b1;
                out_bubble <= 1'b0;
                out_ctrl   <= in_ctrl;
                out_data   <= in_data;
            end else begin
                out_valid  <= 1'b0;
                out_bubble <= 1'b1;
                out_ctrl   <= '0;
            end
        end else if (accept) begin
            // Main entry stalled: park the accepted beat behind it.
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
        end
    end
`else
    assign in_ready = resetn & (~out_valid | out_ready | flush);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            out_valid  <= 1'b0;
            out_bubble <= 1'b1;
            out_ctrl   <= '0;
            out_data   <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_bubble <= 1'b1;
            out_ctrl   <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_bubble <= 1'b0;
            out_ctrl   <= in_ctrl;
            out_data   <= in_data;
        end else if (take) begin
            out_valid  <= 1'b0;
            out_bubble <= 1'b1;
            out_ctrl   <= '0;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (!out_valid && out_ready && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule
